// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants: 640x480@60 defaults, derived totals, counter width.
package vga_timing_pkg;

  localparam int CNT_W = 10;

  localparam int DEF_H_VISIBLE = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;

  localparam int DEF_V_VISIBLE = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;

  localparam int DEF_H_TOTAL = DEF_H_VISIBLE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL = DEF_V_VISIBLE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter with carry out and registered sync/visible
// flags decoded from the next count so they line up with the count they describe.
module vga_axis_counter #(
  parameter int VISIBLE = 640,
  parameter int FP      = 16,
  parameter int SYNC    = 96,
  parameter int BP      = 48,
  parameter int W       = 10
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         carry,
  output logic         sync,
  output logic         visible
);

  localparam int          TOTAL   = VISIBLE + FP + SYNC + BP;
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] SYNC_LO = W'(VISIBLE + FP);
  localparam logic [W-1:0] SYNC_HI = W'(VISIBLE + FP + SYNC - 1);
  localparam logic [W-1:0] VIS_END = W'(VISIBLE);

  logic [W-1:0] count_next;
  logic         sync_next;
  logic         visible_next;

  always_comb begin
    carry      = (count == LAST);
    count_next = count;
    if (step) begin
      count_next = carry ? '0 : count + 1'b1;
    end
    sync_next    = !((count_next >= SYNC_LO) && (count_next <= SYNC_HI));
    visible_next = (count_next < VIS_END);
  end

  // Reset parks the axis on its last position so the first step presents 0.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count   <= LAST;
      sync    <= 1'b1;
      visible <= 1'b0;
    end else begin
      count   <= count_next;
      sync    <= sync_next;
      visible <= visible_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: horizontal and vertical axis counters plus a
// frame-start pulse, all advancing one pixel per enabled clock.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = DEF_H_VISIBLE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_VISIBLE = DEF_V_VISIBLE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  output logic             HSYNC,
  output logic             VSYNC,
  output logic             VIDEO_ON,
  output logic [CNT_W-1:0] HCOUNT,
  output logic [CNT_W-1:0] VCOUNT,
  output logic             FRAME_START
);

  logic h_carry;
  logic v_carry;
  logic h_vis;
  logic v_vis;
  logic v_step;

  assign v_step = EN & h_carry;

  vga_axis_counter #(
    .VISIBLE(H_VISIBLE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .W(CNT_W)
  ) u_h (
    .CLK     (CLK),
    .RST     (RST),
    .step    (EN),
    .count   (HCOUNT),
    .carry   (h_carry),
    .sync    (HSYNC),
    .visible (h_vis)
  );

  vga_axis_counter #(
    .VISIBLE(V_VISIBLE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .W(CNT_W)
  ) u_v (
    .CLK     (CLK),
    .RST     (RST),
    .step    (v_step),
    .count   (VCOUNT),
    .carry   (v_carry),
    .sync    (VSYNC),
    .visible (v_vis)
  );

  // Both visible flags update on the same edge from next-count decode.
  assign VIDEO_ON = h_vis & v_vis;

  // Pulse only on the edge that moves from the last pixel onto (0,0).
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      FRAME_START <= 1'b0;
    end else begin
      FRAME_START <= EN & h_carry & v_carry;
    end
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, default 640, visible pixels per line.
REQ-002 Parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 Parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 Parameter H_BP, default 48, horizontal back porch in pixels.
REQ-005 Parameter V_VISIBLE, default 480, visible lines per frame.
REQ-006 Parameter V_FP, default 10, vertical front porch in lines.
REQ-007 Parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 Parameter V_BP, default 33, vertical back porch in lines.
REQ-009 CLK  input  1  single clock: the ~25 MHz pixel clock produced by the upstream clock divider; all logic is on its rising edge.
REQ-010 RST  input  1  reset: asynchronous, active-low.
REQ-011 EN  input  1  count enable; advance one pixel per CLK edge while high.
REQ-012 HSYNC  output  1  horizontal sync, active-low.
REQ-013 VSYNC  output  1  vertical sync, active-low.
REQ-014 VIDEO_ON  output  1  high while the current pixel is visible.
REQ-015 HCOUNT  output  10  current pixel column.
REQ-016 VCOUNT  output  10  current line.
REQ-017 FRAME_START  output  1  one-cycle pulse on the first pixel of a frame.

Function
REQ-018 H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP (800 at defaults) and V_TOTAL = V_VISIBLE+V_FP+V_SYNC+V_BP (525 at defaults) SHALL be the counter moduli; both SHALL fit in 10 bits.
REQ-019 On each CLK edge with EN=1, HCOUNT SHALL increment; at H_TOTAL-1 it SHALL wrap to 0 and VCOUNT SHALL increment.
REQ-020 When HCOUNT=H_TOTAL-1 and VCOUNT=V_TOTAL-1 with EN=1, both counters SHALL wrap to 0 on the same edge.
REQ-021 With EN=0, all outputs except FRAME_START SHALL hold their values.
REQ-022 HSYNC SHALL be 0 exactly when HCOUNT is in [H_VISIBLE+H_FP, H_VISIBLE+H_FP+H_SYNC-1] (656..751 at defaults), and 1 otherwise.
REQ-023 VSYNC SHALL be 0 exactly when VCOUNT is in [V_VISIBLE+V_FP, V_VISIBLE+V_FP+V_SYNC-1] (490..491), over whole lines, and 1 otherwise.
REQ-024 VIDEO_ON SHALL be 1 exactly when HCOUNT<H_VISIBLE and VCOUNT<V_VISIBLE.
REQ-025 All outputs SHALL be driven from flops, with zero relative skew: HSYNC, VSYNC, VIDEO_ON and FRAME_START in any cycle SHALL decode the HCOUNT/VCOUNT presented in that same cycle, so next-state decode is required.
REQ-026 FRAME_START SHALL be 1 for exactly one CLK cycle: the cycle in which (0,0) is first presented. It SHALL be 0 in every other cycle, including later cycles at (0,0) held by EN=0.

Reset
REQ-027 While RST=0, the block SHALL present HCOUNT=H_TOTAL-1, VCOUNT=V_TOTAL-1, HSYNC=1, VSYNC=1, VIDEO_ON=0 and FRAME_START=0, asynchronously.
REQ-028 The first EN=1 edge after RST release SHALL present (0,0) with VIDEO_ON=1 and FRAME_START=1.
REQ-029 RST asserted mid-frame SHALL immediately return the block to the REQ-027 state; no partial-frame state SHALL survive.

Structure
REQ-030 Package vga_timing_pkg SHALL hold the default timing constants, the derived H_TOTAL/V_TOTAL, and the 10-bit count width.
REQ-031 One sub-module, vga_axis_counter, SHALL be instanced twice (H and V). It SHALL contain the wrapping counter, the carry out, and the registered sync/visible decode for its axis.

Verification
REQ-032 Reset released with EN=1 continuously: FRAME_START occurs at cycle 1, then every 420000 cycles, each time with HCOUNT=0 and VCOUNT=0.
REQ-033 One line at defaults: VIDEO_ON high for 640 cycles; HSYNC low for exactly 96 cycles, starting at HCOUNT=656; line period 800 cycles.
REQ-034 One frame: VSYNC low for 1600 cycles, covering VCOUNT 490..491; VIDEO_ON is never high while VCOUNT>=480.
REQ-035 EN toggled 1-0-0-1 pseudo-randomly: count and decode sequences match the EN=1 run with stalls removed, and FRAME_START never stretches.
REQ-036 RST pulsed low at HCOUNT=300, VCOUNT=200: outputs go to (799,524,1,1,0,0) with no clock edge, and the next enabled edge gives FRAME_START=1.
REQ-037 Wrap at (799,524) with EN=1: both counters go to 0 on the same edge; no (0,524) or (799,0) value ever appears.
